// File: rtl/alu_operand_stage_pkg.sv
// alu_operand_stage_pkg: operand select encodings and default widths shared by the operand stage
package alu_operand_stage_pkg;
  localparam int DATA_LEN = 32;
  localparam int ADDR_LEN = 32;
  localparam int SRC_A_SEL_WIDTH = 2;
  localparam int SRC_B_SEL_WIDTH = 2;
  localparam logic [SRC_A_SEL_WIDTH-1:0] SRC_A_RS1 = 2'd0;
  localparam logic [SRC_A_SEL_WIDTH-1:0] SRC_A_PC = 2'd1;
  localparam logic [SRC_B_SEL_WIDTH-1:0] SRC_B_RS2 = 2'd0;
  localparam logic [SRC_B_SEL_WIDTH-1:0] SRC_B_IMM = 2'd1;
  localparam logic [SRC_B_SEL_WIDTH-1:0] SRC_B_FOUR = 2'd2;
endpackage

// File: rtl/alu_operand_stage_operand_fwd_resolve.sv
// operand_fwd_resolve: register value or lowest-indexed tag-matching forward port
module operand_fwd_resolve #(
  parameter int DATA_LEN = 32,
  parameter int TAG_LEN = 6,
  parameter int NUM_FWD = 2
) (
  input  logic                        rdy,
  input  logic [DATA_LEN-1:0]         reg_data,
  input  logic [TAG_LEN-1:0]          tag,
  input  logic [NUM_FWD-1:0]          fwd_valid,
  input  logic [NUM_FWD*TAG_LEN-1:0]  fwd_tag,
  input  logic [NUM_FWD*DATA_LEN-1:0] fwd_data,
  output logic [DATA_LEN-1:0]         data,
  output logic                        resolved
);
  always_comb begin
    data = reg_data;
    resolved = rdy;
    for (int i = NUM_FWD - 1; i >= 0; i--)
      if (!rdy && fwd_valid[i] && fwd_tag[i*TAG_LEN +: TAG_LEN] == tag) begin
        data = fwd_data[i*DATA_LEN +: DATA_LEN];
        resolved = 1'b1;
      end
  end
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: forwarded operand select into a 2-entry skid buffer; ALU_OPSTAGE_STALL_CNT_EN adds a stall counter
module alu_operand_stage #(
  parameter int DATA_LEN = alu_operand_stage_pkg::DATA_LEN,
  parameter int ADDR_LEN = alu_operand_stage_pkg::ADDR_LEN,
  parameter int TAG_LEN = 6,
  parameter int NUM_FWD = 2
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,
  input  logic                                              flush_i,
  input  logic                                              in_valid_i,
  output logic                                              in_ready_o,
  input  logic [alu_operand_stage_pkg::SRC_A_SEL_WIDTH-1:0] src_a_sel_i,
  input  logic [alu_operand_stage_pkg::SRC_B_SEL_WIDTH-1:0] src_b_sel_i,
  input  logic [ADDR_LEN-1:0]                               pc_i,
  input  logic [DATA_LEN-1:0]                               imm_i,
  input  logic [DATA_LEN-1:0]                               rs1_data_i,
  input  logic [DATA_LEN-1:0]                               rs2_data_i,
  input  logic                                              rs1_rdy_i,
  input  logic                                              rs2_rdy_i,
  input  logic [TAG_LEN-1:0]                                rs1_tag_i,
  input  logic [TAG_LEN-1:0]                                rs2_tag_i,
  input  logic [TAG_LEN-1:0]                                rd_tag_i,
  input  logic [NUM_FWD-1:0]                                fwd_valid_i,
  input  logic [NUM_FWD*TAG_LEN-1:0]                        fwd_tag_i,
  input  logic [NUM_FWD*DATA_LEN-1:0]                       fwd_data_i,
  output logic                                              out_valid_o,
  input  logic                                              out_ready_i,
  output logic [DATA_LEN-1:0]                               alu_src_a_o,
  output logic [DATA_LEN-1:0]                               alu_src_b_o,
  output logic [TAG_LEN-1:0]                                rd_tag_o
`ifdef ALU_OPSTAGE_STALL_CNT_EN
  ,
  input  logic                                              stall_cnt_clr_i,
  output logic [31:0]                                       stall_cnt_o
`endif
);
  import alu_operand_stage_pkg::*;
  logic [DATA_LEN-1:0] rs1_val, rs2_val, a_sel, b_sel, a1, b1;
  logic [TAG_LEN-1:0] t1;
  logic rs1_res, rs2_res, ok, push, pop;
  logic [1:0] count;
  operand_fwd_resolve #(.DATA_LEN(DATA_LEN), .TAG_LEN(TAG_LEN), .NUM_FWD(NUM_FWD)) u_rs1 (
    .rdy(rs1_rdy_i), .reg_data(rs1_data_i), .tag(rs1_tag_i), .fwd_valid(fwd_valid_i),
    .fwd_tag(fwd_tag_i), .fwd_data(fwd_data_i), .data(rs1_val), .resolved(rs1_res)
  );
  operand_fwd_resolve #(.DATA_LEN(DATA_LEN), .TAG_LEN(TAG_LEN), .NUM_FWD(NUM_FWD)) u_rs2 (
    .rdy(rs2_rdy_i), .reg_data(rs2_data_i), .tag(rs2_tag_i), .fwd_valid(fwd_valid_i),
    .fwd_tag(fwd_tag_i), .fwd_data(fwd_data_i), .data(rs2_val), .resolved(rs2_res)
  );
  always_comb begin
    a_sel = src_a_sel_i == SRC_A_RS1 ? rs1_val :
            src_a_sel_i == SRC_A_PC  ? DATA_LEN'(pc_i) : '0;
    b_sel = src_b_sel_i == SRC_B_RS2  ? rs2_val :
            src_b_sel_i == SRC_B_IMM  ? imm_i :
            src_b_sel_i == SRC_B_FOUR ? DATA_LEN'(4) : '0;
    ok = (src_a_sel_i != SRC_A_RS1 || rs1_res) && (src_b_sel_i != SRC_B_RS2 || rs2_res);
  end
  assign in_ready_o = count != 2'd2;
  assign out_valid_o = count != 2'd0;
  assign push = in_valid_i && in_ready_o && ok && !flush_i;
  assign pop = out_valid_o && out_ready_i;
  // entry 0 is the head and drives the outputs directly; entry 1 only fills when the head is stalled
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) begin
      count <= 2'd0;
      alu_src_a_o <= '0;
      alu_src_b_o <= '0;
      rd_tag_o <= '0;
      a1 <= '0;
      b1 <= '0;
      t1 <= '0;
    end else begin
      count <= flush_i ? 2'd0 : count + 2'(push) - 2'(pop);
      if (push && (count == 2'd0 || pop)) begin
        alu_src_a_o <= a_sel;
        alu_src_b_o <= b_sel;
        rd_tag_o <= rd_tag_i;
      end else if (pop && count == 2'd2) begin
        alu_src_a_o <= a1;
        alu_src_b_o <= b1;
        rd_tag_o <= t1;
      end
      if (push && count == 2'd1 && !pop) begin
        a1 <= a_sel;
        b1 <= b_sel;
        t1 <= rd_tag_i;
      end
    end
`ifdef ALU_OPSTAGE_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge reset_i)
    if (!reset_i) stall_cnt_o <= '0;
    else if (stall_cnt_clr_i) stall_cnt_o <= '0;
    else if (in_valid_i && !flush_i && !push && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
`endif
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: scoreboard bench with directed and random traffic; checks stall counter when ALU_OPSTAGE_STALL_CNT_EN is set
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  t;
  } ent_t;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [1:0] sa = 2'd3, sb = 2'd3;
  logic [31:0] pc = 0, imm = 0, r1 = 0, r2 = 0, oa, ob;
  logic r1r = 1, r2r = 1;
  logic [5:0] r1t = 0, r2t = 0, rd = 0, ot;
  logic [1:0] fv = 0;
  logic [11:0] ft = 0;
  logic [63:0] fd = 0;
  int checks = 0, failures = 0;
  ent_t q[$];
`ifdef ALU_OPSTAGE_STALL_CNT_EN
  logic clr = 0;
  logic [31:0] scnt, scnt_m = 0, s0;
`endif
  alu_operand_stage dut (
    .clk_i(clk), .reset_i(rst_n), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .src_a_sel_i(sa), .src_b_sel_i(sb), .pc_i(pc), .imm_i(imm), .rs1_data_i(r1), .rs2_data_i(r2),
    .rs1_rdy_i(r1r), .rs2_rdy_i(r2r), .rs1_tag_i(r1t), .rs2_tag_i(r2t), .rd_tag_i(rd),
    .fwd_valid_i(fv), .fwd_tag_i(ft), .fwd_data_i(fd), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .alu_src_a_o(oa), .alu_src_b_o(ob), .rd_tag_o(ot)
`ifdef ALU_OPSTAGE_STALL_CNT_EN
    , .stall_cnt_clr_i(clr), .stall_cnt_o(scnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [32:0] resolve(input logic rdy, input logic [31:0] d, input logic [5:0] tag);
    if (rdy) return {1'b1, d};
    for (int i = 0; i < 2; i++)
      if (fv[i] && ft[i*6 +: 6] == tag) return {1'b1, fd[i*32 +: 32]};
    return '0;
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q.delete();
`ifdef ALU_OPSTAGE_STALL_CNT_EN
      scnt_m = 0;
`endif
    end else begin : model
      logic [32:0] x1, x2;
      logic need1, need2, acc;
      ent_t e;
      x1 = resolve(r1r, r1, r1t);
      x2 = resolve(r2r, r2, r2t);
      need1 = sa == SRC_A_RS1;
      need2 = sb == SRC_B_RS2;
      e.a = need1 ? x1[31:0] : sa == SRC_A_PC ? pc : 32'd0;
      e.b = need2 ? x2[31:0] : sb == SRC_B_IMM ? imm : sb == SRC_B_FOUR ? 32'd4 : 32'd0;
      e.t = rd;
      acc = in_valid && !flush && q.size() < 2 && (!need1 || x1[32]) && (!need2 || x2[32]);
`ifdef ALU_OPSTAGE_STALL_CNT_EN
      if (clr) scnt_m = 0;
      else if (in_valid && !flush && !acc && scnt_m != 32'hFFFF_FFFF) scnt_m = scnt_m + 1;
`endif
      if (flush) q.delete();
      else begin
        if (q.size() != 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back(e);
      end
    end
  always @(negedge clk) begin
    checks++;
    if (out_valid !== (q.size() != 0)) begin
      failures++;
      $display("FAIL mon_valid: got %0b expected %0b", out_valid, q.size() != 0);
    end
    checks++;
    if (in_ready !== (q.size() < 2)) begin
      failures++;
      $display("FAIL mon_ready: got %0b expected %0b", in_ready, q.size() < 2);
    end
    if (out_valid && q.size() != 0) begin
      checks++;
      if ({oa, ob, ot} !== q[0]) begin
        failures++;
        $display("FAIL mon_head: got a=%h b=%h t=%h expected a=%h b=%h t=%h", oa, ob, ot, q[0].a, q[0].b, q[0].t);
      end
    end
`ifdef ALU_OPSTAGE_STALL_CNT_EN
    checks++;
    if (scnt !== scnt_m) begin
      failures++;
      $display("FAIL mon_stall_cnt: got %0d expected %0d", scnt, scnt_m);
    end
`endif
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic req(input logic [1:0] a_s, input logic [1:0] b_s, input logic [31:0] p, input logic [31:0] im,
                     input logic [5:0] t);
    in_valid = 1;
    sa = a_s;
    sb = b_s;
    pc = p;
    imm = im;
    rd = t;
  endtask
  task automatic idle();
    in_valid = 0;
    flush = 0;
    fv = 0;
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  initial begin
    repeat (3) step();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_a", oa, 0);
    chk("rst_b", ob, 0);
    chk("rst_tag", 32'(ot), 0);
    rst_n = 1;
    out_ready = 1;
    req(SRC_A_PC, SRC_B_FOUR, 32'h8000_0000, 0, 6'd7);
    step();
    chk("pc_a", oa, 32'h8000_0000);
    chk("four_b", ob, 4);
    chk("pc_tag", 32'(ot), 7);
    req(SRC_A_RS1, 2'd3, 0, 0, 6'd8);
    r1r = 0; r1t = 5; r1 = 32'hDEAD;
    fv = 2'b11; ft = {6'd5, 6'd5}; fd = {32'hBB, 32'hAA};
    step();
    chk("fwd_prio0", oa, 32'hAA);
    fv = 2'b10;
    step();
    chk("fwd_prio1", oa, 32'hBB);
    req(2'd2, SRC_B_RS2, 0, 0, 6'd9);
    r1r = 1; r2r = 0; r2t = 3; r2 = 32'hBEEF; fv = 0;
`ifdef ALU_OPSTAGE_STALL_CNT_EN
    s0 = scnt;
`endif
    repeat (4) step();
    chk("unres_valid", 32'(out_valid), 0);
`ifdef ALU_OPSTAGE_STALL_CNT_EN
    chk("stall_cnt_inc", scnt, s0 + 4);
`endif
    fv = 2'b01; ft = {6'd0, 6'd3}; fd = {32'h0, 32'h1234};
    step();
    chk("fwd_b", ob, 32'h1234);
    fv = 0;
    req(2'd2, SRC_B_IMM, 0, 32'h55, 6'd9);
    step();
    chk("imm_b", ob, 32'h55);
    r2r = 1;
    idle();
    step();
    out_ready = 0;
    req(SRC_A_PC, SRC_B_IMM, 1, 1, 6'd10);
    step();
    req(SRC_A_PC, SRC_B_IMM, 2, 2, 6'd11);
    step();
    chk("bp_ready", 32'(in_ready), 0);
    chk("bp_head", 32'(ot), 10);
    req(SRC_A_PC, SRC_B_IMM, 3, 3, 6'd12);
    step();
    chk("bp_head_stable", 32'(ot), 10);
    chk("bp_head_a", oa, 1);
    idle();
    out_ready = 1;
    step();
    chk("bp_pop_b", 32'(ot), 11);
    step();
    chk("bp_empty", 32'(out_valid), 0);
    for (int i = 0; i < 6; i++) begin
      req(SRC_A_PC, SRC_B_FOUR, 32'(i), 0, 6'(20 + i));
      step();
      chk("stream_valid", 32'(out_valid), 1);
      chk("stream_tag", 32'(ot), 32'(20 + i));
    end
    idle();
    step();
    out_ready = 0;
    req(SRC_A_PC, SRC_B_IMM, 30, 30, 6'd30);
    step();
    req(SRC_A_PC, SRC_B_IMM, 31, 31, 6'd31);
    step();
    req(SRC_A_PC, SRC_B_IMM, 32, 32, 6'd32);
    flush = 1;
    step();
    idle();
    chk("flush_valid", 32'(out_valid), 0);
    chk("flush_ready", 32'(in_ready), 1);
    out_ready = 1;
    repeat (3) step();
    out_ready = 0;
    req(SRC_A_PC, SRC_B_IMM, 40, 40, 6'd40);
    step();
    req(SRC_A_PC, SRC_B_IMM, 41, 41, 6'd41);
    step();
    idle();
    #2 rst_n = 0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_ready", 32'(in_ready), 1);
    chk("async_rst_a", oa, 0);
    step();
    rst_n = 1;
    for (int i = 0; i < 600; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      sa = 2'($urandom_range(0, 3));
      sb = 2'($urandom_range(0, 3));
      pc = $urandom;
      imm = $urandom;
      r1 = $urandom;
      r2 = $urandom;
      r1r = $urandom_range(0, 1) != 0;
      r2r = $urandom_range(0, 1) != 0;
      r1t = 6'($urandom_range(0, 7));
      r2t = 6'($urandom_range(0, 7));
      rd = 6'($urandom);
      fv = 2'($urandom);
      ft = {6'($urandom_range(0, 7)), 6'($urandom_range(0, 7))};
      fd = {32'($urandom), 32'($urandom)};
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 19) == 0;
`ifdef ALU_OPSTAGE_STALL_CNT_EN
      clr = $urandom_range(0, 15) == 0;
`endif
      step();
    end
    idle();
    out_ready = 1;
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
